frame_serializer: RTL and testbench

FRAME_SERIALIZER -- requirements
Module: frame_serializer

---
 rtl/frame_serializer.sv | 187 ++++++++++++++++++
 tb/tb_frame_serializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_serializer.sv
// frame_serializer: word FIFO feeding a start/data/stop serial framer.
// One bit is sent per clk_i cycle on a registered sdata_o, and en_o marks frame bits.
// The head word is popped in the last stop-bit cycle, together with done_o.
// Optional even-parity bit: define FRAME_SERIALIZER_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a word in the FIFO
// START  | start bit (0)
// DATA   | DATA_W data bits, LSB or MSB first
// PARITY | even parity of the head word (parity build only)
// STOP   | STOP_BITS stop bits (1), pop on the last one
module frame_serializer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 5,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       sdata_o,
  output logic                       en_o,
  output logic                       done_o,
  output logic                       ovf_o
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DATA_W+1);

  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH-1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W-1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS-1);

`ifdef FRAME_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic                armed_q;
  logic                sdata_q, en_q, done_q, ovf_q;
  logic                sdata_d, en_d, done_d;
  logic                push, pop;
  logic [DATA_W-1:0]   head, head_sh;

  assign busy_o  = (level_q == LVL_FULL);
  assign level_o = level_q;
  assign sdata_o = sdata_q;
  assign en_o    = en_q;
  assign done_o  = done_q;
  assign ovf_o   = ovf_q;

  assign push = en_i && !busy_o;
  assign pop  = (state_q == STOP) && (cnt_q == STOP_LAST);
  assign head = mem[rd_ptr_q];

  // Next FIFO occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Word storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // FIFO pointers, occupancy, launch arming and overflow pulse.
  // armed_q delays the IDLE launch by one cycle after a word becomes visible,
  // which fixes the write-to-start-bit latency at two edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      armed_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      armed_q <= (level_q != '0);
      ovf_q   <= en_i && busy_o;
    end
  end

  // Next-state logic; the bit counter restarts on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && (level_q != '0)) begin
          state_d = START;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          cnt_d   = '0;
`ifdef FRAME_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef FRAME_SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = STOP;
        cnt_d   = '0;
      end
`endif
      STOP: begin
        if (pop) begin
          cnt_d   = '0;
          state_d = (level_d != '0) ? START : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line outputs for the coming cycle, derived from the next state so that
  // the registered outputs line up with the state they describe.
  always_comb begin
    sdata_d = 1'b1;
    en_d    = 1'b1;
    done_d  = 1'b0;
    head_sh = head >> ((MSB_FIRST != 0) ? (DATA_LAST - cnt_d) : cnt_d);
    case (state_d)
      IDLE:   en_d = 1'b0;
      START:  sdata_d = 1'b0;
      DATA:   sdata_d = head_sh[0];
`ifdef FRAME_SERIALIZER_PARITY_EN
      PARITY: sdata_d = ^head;
`endif
      STOP:   done_d = (cnt_d == STOP_LAST);
      default: en_d = 1'b0;
    endcase
  end

  // State, bit counter and registered line outputs; reset aborts any frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdata_q <= 1'b1;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdata_q <= sdata_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed checks of frame_serializer with default
// parameters and with a 12-bit, 2-stop-bit, MSB-first instance.
module tb_frame_serializer;

`ifdef FRAME_SERIALIZER_PARITY_EN
  localparam int FL1 = 11;
  localparam int FL2 = 16;
  localparam logic [63:0] SEQ_A5  = 64'h54A;
  localparam logic [63:0] SEQ_38  = 64'h670;
  localparam logic [63:0] SEQ_FFF = 64'hDFFE;
  localparam logic [63:0] SEQ_801 = 64'hD002;
`else
  localparam int FL1 = 10;
  localparam int FL2 = 15;
  localparam logic [63:0] SEQ_A5  = 64'h34A;
  localparam logic [63:0] SEQ_38  = 64'h270;
  localparam logic [63:0] SEQ_FFF = 64'h7FFE;
  localparam logic [63:0] SEQ_801 = 64'h7002;
`endif

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic [7:0]  data_i;
  logic        busy_o;
  logic [2:0]  level_o;
  logic        sdata_o, en_o, done_o, ovf_o;

  logic        en2_i;
  logic [11:0] data2_i;
  logic        busy2_o;
  logic [1:0]  level2_o;
  logic        sdata2_o, en2_o, done2_o, ovf2_o;

  int n_assert;
  int n_fail;
  logic [63:0] seq_a5, seq_38, seq_two;

  frame_serializer dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i),
    .busy_o(busy_o), .level_o(level_o), .sdata_o(sdata_o),
    .en_o(en_o), .done_o(done_o), .ovf_o(ovf_o)
  );

  frame_serializer #(.DATA_W(12), .DEPTH(3), .STOP_BITS(2), .MSB_FIRST(1)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en2_i), .data_i(data2_i),
    .busy_o(busy2_o), .level_o(level2_o), .sdata_o(sdata2_o),
    .en_o(en2_o), .done_o(done2_o), .ovf_o(ovf2_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one frame of the default instance from its start bit onward.
  task automatic expect_frame1(input string tag, input logic [63:0] seq, input int n,
                               input logic [2:0] exp_level);
    int bd, be, bdn, bl;
    bd = 0; be = 0; bdn = 0; bl = 0;
    for (int i = 0; i < n; i++) begin
      if (sdata_o !== seq[i]) bd++;
      if (en_o !== 1'b1) be++;
      if (done_o !== ((i == n-1) ? 1'b1 : 1'b0)) bdn++;
      if (level_o !== exp_level) bl++;
      tick();
    end
    chk({tag, "_sdata_errs"}, 64'(bd), 64'd0);
    chk({tag, "_en_errs"}, 64'(be), 64'd0);
    chk({tag, "_done_errs"}, 64'(bdn), 64'd0);
    chk({tag, "_level_errs"}, 64'(bl), 64'd0);
  endtask

  initial begin
    int bd, be, bdn, bl, bb, w;
    n_assert = 0;
    n_fail   = 0;
    seq_a5   = SEQ_A5;
    seq_38   = SEQ_38;
    seq_two  = SEQ_FFF | (SEQ_801 << FL2);
    rst_i = 1'b1; en_i = 1'b0; data_i = '0; en2_i = 1'b0; data2_i = '0;

    // Reset state
    tick(); tick();
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_sdata", 64'(sdata_o), 64'd1);
    chk("rst_en", 64'(en_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);

    // Single 0xA5 frame, write on the first edge after reset release
    rst_i = 1'b0; en_i = 1'b1; data_i = 8'hA5;
    tick();
    chk("a5_level_after_write", 64'(level_o), 64'd1);
    en_i = 1'b0;
    tick();
    chk("a5_idle_sdata", 64'(sdata_o), 64'd1);
    chk("a5_idle_en", 64'(en_o), 64'd0);
    tick();
    expect_frame1("a5", seq_a5, FL1, 3'd1);
    chk("a5_level_end", 64'(level_o), 64'd0);
    chk("a5_en_end", 64'(en_o), 64'd0);
    chk("a5_sdata_end", 64'(sdata_o), 64'd1);

    // Six consecutive writes: fifth fills the FIFO, sixth overflows
    for (int k = 0; k < 6; k++) begin
      en_i = 1'b1;
      data_i = (k == 5) ? 8'h00 : 8'hA5;
      tick();
      if (k < 4) begin
        chk("b2b_level_fill", 64'(level_o), 64'(k + 1));
        chk("b2b_busy_fill", 64'(busy_o), 64'd0);
      end else if (k == 4) begin
        chk("b2b_busy_full", 64'(busy_o), 64'd1);
        chk("b2b_level_full", 64'(level_o), 64'd5);
      end else begin
        chk("b2b_ovf_pulse", 64'(ovf_o), 64'd1);
        chk("b2b_level_drop", 64'(level_o), 64'd5);
      end
    end
    en_i = 1'b0;
    tick();
    chk("b2b_ovf_clear", 64'(ovf_o), 64'd0);
    bd = 0; be = 0; bdn = 0; bl = 0; bb = 0;
    for (int i = 4; i < 5*FL1; i++) begin
      if (en_o !== 1'b1) be++;
      if (sdata_o !== seq_a5[i % FL1]) bd++;
      if (done_o !== (((i % FL1) == FL1-1) ? 1'b1 : 1'b0)) bdn++;
      if (level_o !== 3'(5 - i / FL1)) bl++;
      if (busy_o !== ((i < FL1) ? 1'b1 : 1'b0)) bb++;
      tick();
    end
    chk("b2b_en_gaps", 64'(be), 64'd0);
    chk("b2b_sdata_errs", 64'(bd), 64'd0);
    chk("b2b_done_errs", 64'(bdn), 64'd0);
    chk("b2b_level_errs", 64'(bl), 64'd0);
    chk("b2b_busy_errs", 64'(bb), 64'd0);
    chk("b2b_en_end", 64'(en_o), 64'd0);
    chk("b2b_level_end", 64'(level_o), 64'd0);

    // Full FIFO, write on the done cycle is refused, next write accepted
    for (int k = 0; k < 5; k++) begin
      en_i = 1'b1; data_i = 8'hA5;
      tick();
    end
    en_i = 1'b0;
    chk("full_level", 64'(level_o), 64'd5);
    w = 0;
    while (done_o !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    chk("full_done_seen", 64'(done_o), 64'd1);
    en_i = 1'b1; data_i = 8'h11;
    tick();
    chk("full_ovf_on_pop", 64'(ovf_o), 64'd1);
    chk("full_level_after_pop", 64'(level_o), 64'd4);
    data_i = 8'h5A;
    tick();
    en_i = 1'b0;
    chk("full_level_refill", 64'(level_o), 64'd5);
    chk("full_ovf_clear", 64'(ovf_o), 64'd0);

    // Reset during data bit 4 of the frame in flight
    tick(); tick(); tick(); tick();
    chk("mid_sdata_bit4", 64'(sdata_o), 64'd0);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_sdata", 64'(sdata_o), 64'd1);
    chk("mid_rst_en", 64'(en_o), 64'd0);
    chk("mid_rst_level", 64'(level_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    tick();
    chk("mid_rst_done", 64'(done_o), 64'd0);
    tick();
    rst_i = 1'b0; en_i = 1'b1; data_i = 8'h38;
    tick();
    en_i = 1'b0;
    chk("post_rst_level", 64'(level_o), 64'd1);
    chk("post_rst_done", 64'(done_o), 64'd0);
    tick(); tick();
    expect_frame1("post_rst_38", seq_38, FL1, 3'd1);
    chk("post_rst_level_end", 64'(level_o), 64'd0);

    // 12-bit MSB-first instance, two stop bits, two frames back to back
    en2_i = 1'b1; data2_i = 12'hFFF;
    tick();
    chk("w12_level_1", 64'(level2_o), 64'd1);
    data2_i = 12'h801;
    tick();
    en2_i = 1'b0;
    chk("w12_level_2", 64'(level2_o), 64'd2);
    tick();
    bd = 0; be = 0; bdn = 0; bl = 0;
    for (int i = 0; i < 2*FL2; i++) begin
      if (sdata2_o !== seq_two[i]) bd++;
      if (en2_o !== 1'b1) be++;
      if (done2_o !== (((i % FL2) == FL2-1) ? 1'b1 : 1'b0)) bdn++;
      if (level2_o !== ((i < FL2) ? 2'd2 : 2'd1)) bl++;
      tick();
    end
    chk("w12_sdata_errs", 64'(bd), 64'd0);
    chk("w12_en_errs", 64'(be), 64'd0);
    chk("w12_done_errs", 64'(bdn), 64'd0);
    chk("w12_level_errs", 64'(bl), 64'd0);
    chk("w12_level_end", 64'(level2_o), 64'd0);
    chk("w12_en_end", 64'(en2_o), 64'd0);
    chk("w12_sdata_end", 64'(sdata2_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
